// File: rtl/avalon_mm_fabric_pkg.sv
// Shared types and default address map for the Avalon-MM fabric.
// The default map has two agents: ROM at 0x0000_0000 and RAM at 0x0001_0000, 64 KiB each.
package avalon_mm_fabric_pkg;

   // Index of an agent port; the value NUM_AGENTS is the error slot.
   typedef logic [3:0] agent_idx_t;

   localparam logic [1:0][31:0] DEFAULT_BASE = {32'h0001_0000, 32'h0000_0000};
   localparam logic [1:0][31:0] DEFAULT_MASK = {32'hFFFF_0000, 32'hFFFF_0000};
   localparam logic [31:0]      ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/avalon_mm_fabric_if.sv
// Host-side and agent-side Avalon-MM signal bundle for the fabric.
// The slave modport is the fabric's view; the master modport is the view of the host and agents around it.
interface avalon_mm_fabric_if #(
   parameter int NUM_AGENTS = 2,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
);
   localparam int BE_W = DATA_W / 8;

   logic [ADDR_W-1:0]                  host_address;
   logic                               host_read;
   logic                               host_write;
   logic [DATA_W-1:0]                  host_writedata;
   logic [BE_W-1:0]                    host_byteenable;
   logic                               host_waitrequest;
   logic [DATA_W-1:0]                  host_readdata;
   logic                               host_readdatavalid;

   logic [NUM_AGENTS-1:0][ADDR_W-1:0]  agent_address;
   logic [NUM_AGENTS-1:0]              agent_read;
   logic [NUM_AGENTS-1:0]              agent_write;
   logic [NUM_AGENTS-1:0][DATA_W-1:0]  agent_writedata;
   logic [NUM_AGENTS-1:0][BE_W-1:0]    agent_byteenable;
   logic [NUM_AGENTS-1:0]              agent_waitrequest;
   logic [NUM_AGENTS-1:0][DATA_W-1:0]  agent_readdata;
   logic [NUM_AGENTS-1:0]              agent_readdatavalid;

   modport slave (
      input  host_address, host_read, host_write, host_writedata, host_byteenable,
      output host_waitrequest, host_readdata, host_readdatavalid,
      output agent_address, agent_read, agent_write, agent_writedata, agent_byteenable,
      input  agent_waitrequest, agent_readdata, agent_readdatavalid
   );

   modport master (
      output host_address, host_read, host_write, host_writedata, host_byteenable,
      input  host_waitrequest, host_readdata, host_readdatavalid,
      input  agent_address, agent_read, agent_write, agent_writedata, agent_byteenable,
      output agent_waitrequest, agent_readdata, agent_readdatavalid
   );

endinterface

// File: rtl/avalon_mm_fabric_decoder.sv
// Combinational address decoder: picks the lowest-index agent whose base/mask matches.
// When no agent matches, it returns the error slot (NUM_AGENTS).
module avalon_mm_fabric_decoder
   import avalon_mm_fabric_pkg::*;
#(
   parameter int NUM_AGENTS = 2,
   parameter int ADDR_W     = 32,
   parameter logic [NUM_AGENTS-1:0][ADDR_W-1:0] AGENT_BASE = DEFAULT_BASE,
   parameter logic [NUM_AGENTS-1:0][ADDR_W-1:0] AGENT_MASK = DEFAULT_MASK
) (
   input  logic [ADDR_W-1:0] address,
   output agent_idx_t        target,
   output logic              miss
);

   always_comb begin
      target = agent_idx_t'(NUM_AGENTS);
      miss   = 1'b1;
      // Walk downwards so the lowest matching index is the last one written.
      for (int i = NUM_AGENTS - 1; i >= 0; i--) begin
         if ((address & AGENT_MASK[i]) == AGENT_BASE[i]) begin
            target = agent_idx_t'(i);
            miss   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/avalon_mm_fabric.sv
// Avalon-MM interconnect: one host fanned out to NUM_AGENTS agents by address decode.
// Pipelined reads stay in order, and unmapped accesses are answered with ERR_DATA.
module avalon_mm_fabric
   import avalon_mm_fabric_pkg::*;
#(
   parameter int NUM_AGENTS  = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_PENDING = 4,
   parameter logic [NUM_AGENTS-1:0][ADDR_W-1:0] AGENT_BASE = DEFAULT_BASE,
   parameter logic [NUM_AGENTS-1:0][ADDR_W-1:0] AGENT_MASK = DEFAULT_MASK,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
   input  logic               clk,
   input  logic               rst,
   avalon_mm_fabric_if.slave  bus,
   output logic               decode_err,
   output logic [7:0]         err_count
);

   localparam int PEND_W = 4;

   agent_idx_t        target;
   agent_idx_t        active;
   logic              miss;
   logic [PEND_W-1:0] pending;
   logic              err_rsp_q;

   logic              pend_nz, stall, tgt_wait, waitreq;
   logic              act_rdv, mapped_rsp, rsp, stray;
   logic              rd_accept, wr_accept, err_evt;
   logic [DATA_W-1:0] act_rdata;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   avalon_mm_fabric_decoder #(
      .NUM_AGENTS (NUM_AGENTS),
      .ADDR_W     (ADDR_W),
      .AGENT_BASE (AGENT_BASE),
      .AGENT_MASK (AGENT_MASK)
   ) u_decoder (
      .address (bus.host_address),
      .target  (target),
      .miss    (miss)
   );

   always_comb begin
      pend_nz   = (pending != '0);
      stall     = (pend_nz && (target != active)) ||
                  (bus.host_read && (pending == PEND_W'(MAX_PENDING)));
      tgt_wait  = 1'b0;
      act_rdv   = 1'b0;
      act_rdata = '0;
      stray     = 1'b0;
      for (int i = 0; i < NUM_AGENTS; i++) begin
         if (target == agent_idx_t'(i)) tgt_wait = bus.agent_waitrequest[i];
         if (active == agent_idx_t'(i)) begin
            act_rdv   = bus.agent_readdatavalid[i];
            act_rdata = bus.agent_readdata[i];
         end
         // Only the active agent may respond, and only while reads are outstanding.
         if (bus.agent_readdatavalid[i] && !(pend_nz && (active == agent_idx_t'(i))))
            stray = 1'b1;
      end

      waitreq    = !rst || stall || tgt_wait;
      rd_accept  = bus.host_read  && !waitreq;
      wr_accept  = bus.host_write && !waitreq;
      mapped_rsp = pend_nz && act_rdv;
      rsp        = mapped_rsp || err_rsp_q;
      err_evt    = ((rd_accept || wr_accept) && miss) || stray;

      bus.host_waitrequest   = waitreq;
      bus.host_readdatavalid = rsp;
      bus.host_readdata      = mapped_rsp ? act_rdata : (err_rsp_q ? ERR_DATA : '0);

      for (int i = 0; i < NUM_AGENTS; i++) begin
         bus.agent_address[i]    = bus.host_address;
         bus.agent_writedata[i]  = bus.host_writedata;
         bus.agent_byteenable[i] = bus.host_byteenable;
         bus.agent_read[i]       = rst && bus.host_read  && (target == agent_idx_t'(i)) && !stall;
         bus.agent_write[i]      = rst && bus.host_write && (target == agent_idx_t'(i)) && !stall;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending    <= '0;
         active     <= '0;
         err_rsp_q  <= 1'b0;
         decode_err <= 1'b0;
         err_count  <= '0;
      end else begin
         // The error slot answers one cycle after it accepts, one response per read.
         err_rsp_q <= rd_accept && miss;
         if (rd_accept) active <= target;
         case ({rd_accept, rsp})
            2'b10:   pending <= pending + 1'b1;
            2'b01:   pending <= pending - 1'b1;
            default: pending <= pending;
         endcase
         if (err_evt) begin
            decode_err <= 1'b1;
            err_count  <= sat_inc(err_count);
         end
      end
   end

endmodule

// File: tb/tb_avalon_mm_fabric.sv
// Directed bench for avalon_mm_fabric; the bench itself plays the ROM (agent 0) and RAM (agent 1) agents.
// Expected values are hand-computed per cycle.
module tb_avalon_mm_fabric;

   logic       clk = 1'b0;
   logic       rst;
   logic       decode_err;
   logic [7:0] err_count;

   int checks   = 0;
   int failures = 0;

   avalon_mm_fabric_if #(.NUM_AGENTS(2), .ADDR_W(32), .DATA_W(32)) bus ();

   avalon_mm_fabric dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .decode_err (decode_err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.host_read           = 1'b0;
      bus.host_write          = 1'b0;
      bus.agent_waitrequest   = '0;
      bus.agent_readdatavalid = '0;
      bus.agent_readdata      = '0;
   endtask

   task automatic rd(input logic [31:0] a);
      bus.host_address = a;
      bus.host_read    = 1'b1;
      bus.host_write   = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.host_address    = a;
      bus.host_writedata  = d;
      bus.host_byteenable = be;
      bus.host_write      = 1'b1;
      bus.host_read       = 1'b0;
   endtask

   task automatic rsp(input logic idx, input logic [31:0] d);
      bus.agent_readdatavalid[idx] = 1'b1;
      bus.agent_readdata[idx]      = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst                 = 1'b0;
      bus.host_address    = '0;
      bus.host_writedata  = '0;
      bus.host_byteenable = '0;
      idle();
      rd(32'h0000_0010);
      repeat (2) @(posedge clk);
      #1;
      check("rst_wait",    32'(bus.host_waitrequest), 32'd1);
      check("rst_agrd",    32'(bus.agent_read), 32'd0);
      check("rst_rdv",     32'(bus.host_readdatavalid), 32'd0);
      check("rst_err",     32'(decode_err), 32'd0);
      check("rst_cnt",     32'(err_count), 32'd0);
      idle();
      rst = 1'b1;
      tick();

      // Two pipelined ROM reads, latency 2, in-order responses.
      rd(32'h0000_0010); #1;
      check("s1_wait0", 32'(bus.host_waitrequest), 32'd0);
      check("s1_sel0",  32'(bus.agent_read), 32'd1);
      tick();
      rd(32'h0000_0014); #1;
      check("s1_wait1", 32'(bus.host_waitrequest), 32'd0);
      tick();
      idle(); rsp(1'b0, 32'hA0A0_0010); #1;
      check("s1_pend2", 32'(dut.pending), 32'd2);
      check("s1_rdv0",  32'(bus.host_readdatavalid), 32'd1);
      check("s1_dat0",  bus.host_readdata, 32'hA0A0_0010);
      tick();
      idle(); rsp(1'b0, 32'hA0A0_0014); #1;
      check("s1_rdv1",  32'(bus.host_readdatavalid), 32'd1);
      check("s1_dat1",  bus.host_readdata, 32'hA0A0_0014);
      tick();
      idle(); #1;
      check("s1_pend0", 32'(dut.pending), 32'd0);
      check("s1_idle",  32'(bus.host_readdatavalid), 32'd0);
      check("s1_zero",  bus.host_readdata, 32'd0);

      // ROM read then RAM read: RAM held off until the ROM answers.
      tick();
      rd(32'h0000_0000); #1;
      check("s2_rom_wait", 32'(bus.host_waitrequest), 32'd0);
      tick();
      idle(); rd(32'h0001_0000); #1;
      check("s2_ram_hold", 32'(bus.host_waitrequest), 32'd1);
      check("s2_ram_nord", 32'(bus.agent_read), 32'd0);
      tick();
      idle(); rd(32'h0001_0000); rsp(1'b0, 32'hA0A0_0000); #1;
      check("s2_hold2",    32'(bus.host_waitrequest), 32'd1);
      check("s2_rom_rdv",  32'(bus.host_readdatavalid), 32'd1);
      check("s2_rom_dat",  bus.host_readdata, 32'hA0A0_0000);
      tick();
      idle(); rd(32'h0001_0000); #1;
      check("s2_ram_go",   32'(bus.host_waitrequest), 32'd0);
      check("s2_ram_sel",  32'(bus.agent_read), 32'd2);
      tick();
      idle(); rsp(1'b1, 32'hB0B0_0000); #1;
      check("s2_ram_rdv",  32'(bus.host_readdatavalid), 32'd1);
      check("s2_ram_dat",  bus.host_readdata, 32'hB0B0_0000);
      check("s2_cnt",      32'(err_count), 32'd0);
      tick();

      // Unmapped reads, single then back-to-back.
      idle(); rd(32'h8000_0000); #1;
      check("s3_wait",  32'(bus.host_waitrequest), 32'd0);
      check("s3_nord",  32'(bus.agent_read), 32'd0);
      tick();
      idle(); #1;
      check("s3_rdv",   32'(bus.host_readdatavalid), 32'd1);
      check("s3_dat",   bus.host_readdata, 32'hDEAD_BEEF);
      check("s3_err",   32'(decode_err), 32'd1);
      check("s3_cnt",   32'(err_count), 32'd1);
      tick();
      rd(32'h8000_0000); tick();
      rd(32'h9000_0004); #1;
      check("s3_b2b_wait", 32'(bus.host_waitrequest), 32'd0);
      check("s3_b2b_rdv0", 32'(bus.host_readdatavalid), 32'd1);
      tick();
      idle(); #1;
      check("s3_b2b_rdv1", 32'(bus.host_readdatavalid), 32'd1);
      check("s3_b2b_dat1", bus.host_readdata, 32'hDEAD_BEEF);
      check("s3_b2b_cnt",  32'(err_count), 32'd3);
      tick();
      #1;
      check("s3_done_rdv", 32'(bus.host_readdatavalid), 32'd0);
      check("s3_done_pnd", 32'(dut.pending), 32'd0);

      // Fifth outstanding read stalls until the first response returns.
      for (int k = 0; k < 4; k++) begin
         idle(); rd(32'h0000_0020 + 32'(4 * k)); #1;
         check("s4_acc", 32'(bus.host_waitrequest), 32'd0);
         tick();
      end
      idle(); rd(32'h0000_0030); #1;
      check("s4_full_wait", 32'(bus.host_waitrequest), 32'd1);
      check("s4_full_pend", 32'(dut.pending), 32'd4);
      tick();
      idle(); rd(32'h0000_0030); rsp(1'b0, 32'hA0A0_0020); #1;
      check("s4_rsp_wait",  32'(bus.host_waitrequest), 32'd1);
      check("s4_rsp_dat",   bus.host_readdata, 32'hA0A0_0020);
      tick();
      idle(); rd(32'h0000_0030); #1;
      check("s4_5th_acc",   32'(bus.host_waitrequest), 32'd0);
      check("s4_5th_pend",  32'(dut.pending), 32'd3);
      tick();
      for (int k = 0; k < 4; k++) begin
         idle(); rsp(1'b0, 32'hA0A0_0024 + 32'(4 * k)); #1;
         check("s4_drain", bus.host_readdata, 32'hA0A0_0024 + 32'(4 * k));
         tick();
      end
      idle(); #1;
      check("s4_pend0", 32'(dut.pending), 32'd0);

      // RAM write with three wait cycles, then an unmapped write.
      wr(32'h0001_0004, 32'hCAFE_F00D, 4'b0011);
      bus.agent_waitrequest[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("s5_wait", 32'(bus.host_waitrequest), 32'd1);
         check("s5_wsel", 32'(bus.agent_write), 32'd2);
         tick();
      end
      bus.agent_waitrequest[1] = 1'b0; #1;
      check("s5_go",    32'(bus.host_waitrequest), 32'd0);
      check("s5_wsel2", 32'(bus.agent_write), 32'd2);
      check("s5_wdat",  bus.agent_writedata[1], 32'hCAFE_F00D);
      check("s5_wdat0", bus.agent_writedata[0], 32'hCAFE_F00D);
      check("s5_be",    32'(bus.agent_byteenable[1]), 32'h3);
      check("s5_addr",  bus.agent_address[1], 32'h0001_0004);
      tick();
      idle(); #1;
      check("s5_idle",  32'(bus.agent_write), 32'd0);
      wr(32'hF000_0000, 32'h1111_2222, 4'hF); #1;
      check("s5_unm_wait", 32'(bus.host_waitrequest), 32'd0);
      check("s5_unm_wsel", 32'(bus.agent_write), 32'd0);
      tick();
      idle(); #1;
      check("s5_unm_cnt",  32'(err_count), 32'd4);

      // Stray response with nothing outstanding is swallowed and counted.
      rsp(1'b1, 32'h1234_5678); #1;
      check("s6_stray_rdv", 32'(bus.host_readdatavalid), 32'd0);
      check("s6_stray_dat", bus.host_readdata, 32'd0);
      tick();
      idle(); #1;
      check("s6_stray_cnt", 32'(err_count), 32'd5);

      // Error counter saturates.
      rsp(1'b0, 32'h0000_0001);
      repeat (260) tick();
      idle(); #1;
      check("s7_sat", 32'(err_count), 32'd255);

      // Reset with two reads in flight; late responses become stray errors.
      rd(32'h0000_0040); tick();
      rd(32'h0000_0044); tick();
      idle(); #1;
      check("s8_pend2", 32'(dut.pending), 32'd2);
      rst = 1'b0; #1;
      check("s8_rst_pend", 32'(dut.pending), 32'd0);
      check("s8_rst_wait", 32'(bus.host_waitrequest), 32'd1);
      check("s8_rst_cnt",  32'(err_count), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      rsp(1'b0, 32'hA0A0_0040); #1;
      check("s8_late0", 32'(bus.host_readdatavalid), 32'd0);
      tick();
      idle(); rsp(1'b0, 32'hA0A0_0044); #1;
      check("s8_late1", 32'(bus.host_readdatavalid), 32'd0);
      tick();
      idle(); #1;
      check("s8_cnt",  32'(err_count), 32'd2);
      check("s8_err",  32'(decode_err), 32'd1);
      check("s8_pend", 32'(dut.pending), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
